// File: rtl/usb_nrzi_stuff_tx.sv
// USB full-speed transmit line encoder: word serialiser with bit stuffing,
// NRZI encoding, J/K/SE0 pad drive and EOP generation.
module usb_nrzi_stuff_tx #(
    parameter int DATA_W       = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tx_oe,
    output logic              tx_dp,
    output logic              tx_dm,
    output logic              tx_nrzi,
    output logic              busy,
    output logic              underrun
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam int EOP_W = $clog2(EOP_SE0_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              last_acc;
    logic              eow_pend;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  ones_cnt;
    logic [EOP_W-1:0]  eop_cnt;

    logic accept;
    logic cur_bit;
    logic word_end;
    logic stuff_due;
    logic load_first;
    logic eow;
    logic reload_buf;
    logic reload_in;
    logic load_buf;
    logic shift_en;
    logic data_lvl;

    function automatic logic nrzi_step(input logic level, input logic data_bit);
        return data_bit ? level : ~level;
    endfunction

    assign in_ready = !buf_full && (state == IDLE || state == SHIFT) && !last_acc;

    always_comb begin
        accept     = in_valid && in_ready;
        cur_bit    = shreg[0];
        word_end   = (bit_idx == IDX_W'(DATA_W - 1));
        stuff_due  = cur_bit && (ones_cnt == CNT_W'(STUFF_LEN - 1));
        load_first = (state == IDLE) && accept;
        data_lvl   = nrzi_step(tx_nrzi, cur_bit);
        eow        = 1'b0;
        if (bit_en) begin
            if (state == SHIFT)
                eow = word_end && !stuff_due;
            else if (state == STUFF)
                eow = eow_pend;
        end
        reload_buf = eow && buf_full;
        // A word arriving on the very edge the shifter runs dry goes straight in.
        reload_in  = eow && !buf_full && accept;
        load_buf   = accept && !load_first && !reload_in;
        shift_en   = (state == SHIFT) && bit_en && !word_end;
    end

    // Data registers carry no reset; buf_full and the FSM qualify their contents.
    always_ff @(posedge clk) begin
        if (load_first || reload_in)
            shreg <= in_data;
        else if (reload_buf)
            shreg <= buf_data;
        else if (shift_en)
            shreg <= shreg >> 1;
        if (load_buf)
            buf_data <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            last_acc <= 1'b0;
            eow_pend <= 1'b0;
            bit_idx  <= '0;
            ones_cnt <= '0;
            eop_cnt  <= '0;
            tx_oe    <= 1'b0;
            tx_dp    <= 1'b1;
            tx_dm    <= 1'b0;
            tx_nrzi  <= 1'b1;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept && in_last)
                last_acc <= 1'b1;
            if (load_buf)
                buf_full <= 1'b1;
            else if (reload_buf)
                buf_full <= 1'b0;
            if (eow || load_first)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;

            case (state)
                IDLE: begin
                    if (load_first) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        ones_cnt <= '0;
                        eow_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        tx_oe    <= 1'b1;
                        tx_nrzi  <= data_lvl;
                        tx_dp    <= data_lvl;
                        tx_dm    <= ~data_lvl;
                        ones_cnt <= cur_bit ? ones_cnt + 1'b1 : '0;
                        if (stuff_due) begin
                            state    <= STUFF;
                            eow_pend <= word_end;
                        end
                    end
                end
                STUFF: begin
                    if (bit_en) begin
                        tx_nrzi  <= ~tx_nrzi;
                        tx_dp    <= ~tx_nrzi;
                        tx_dm    <= tx_nrzi;
                        ones_cnt <= '0;
                        eow_pend <= 1'b0;
                        if (!eow_pend)
                            state <= SHIFT;
                    end
                end
                EOP_SE0: begin
                    if (bit_en) begin
                        tx_oe <= 1'b1;
                        tx_dp <= 1'b0;
                        tx_dm <= 1'b0;
                        if (eop_cnt == EOP_W'(EOP_SE0_BITS - 1)) begin
                            eop_cnt <= '0;
                            state   <= EOP_J;
                        end else begin
                            eop_cnt <= eop_cnt + 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    // First strobe drives J, the second releases the bus.
                    if (bit_en) begin
                        if (eop_cnt == '0) begin
                            tx_oe   <= 1'b1;
                            tx_dp   <= 1'b1;
                            tx_dm   <= 1'b0;
                            tx_nrzi <= 1'b1;
                            eop_cnt <= 1;
                        end else begin
                            tx_oe    <= 1'b0;
                            eop_cnt  <= '0;
                            busy     <= 1'b0;
                            last_acc <= 1'b0;
                            ones_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (eow) begin
                if (reload_buf || reload_in) begin
                    state <= SHIFT;
                end else begin
                    state    <= EOP_SE0;
                    eop_cnt  <= '0;
                    underrun <= !last_acc;
                end
            end
        end
    end

endmodule

// File: doc/usb_nrzi_stuff_tx.md
Name: usb_nrzi_stuff_tx

Overview:
Parametrised USB transmit line encoder, the successor to the single-bit NRZI stage. Accepts parallel words over a valid/ready stream and serialises them LSB first. Inserts a stuffed zero after every STUFF_LEN consecutive ones, NRZI-encodes the result, and drives full-speed differential J/K/SE0 with output enable, including EOP generation. Sits between the packet assembler (which supplies SYNC, PID, payload and CRC as data) and the pad drivers.

Parameters:
DATA_W, 8, width of input word; bits sent LSB first
STUFF_LEN, 6, run of consecutive ones after which a stuffed 0 is inserted (>=1)
EOP_SE0_BITS, 2, number of SE0 bit times in EOP (>=1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
bit_en  input  1  bit-rate strobe; line state advances only on clk edges with bit_en=1
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data valid
in_last  input  1  word is last of packet; qualified with in_valid
in_ready  output  1  block accepts word on clk edge where in_valid&in_ready
tx_oe  output  1  pad output enable
tx_dp  output  1  D+ drive level
tx_dm  output  1  D- drive level
tx_nrzi  output  1  current NRZI level (1=J, 0=K), diagnostic
busy  output  1  high from first acceptance until return to IDLE
underrun  output  1  one-clk pulse when the shifter needs a word and none is buffered before in_last was seen

Behaviour:
- Reset values: tx_oe=0, tx_dp=1, tx_dm=0, tx_nrzi=1, busy=0, underrun=0, in_ready=1. Shifter and buffer empty, ones counter 0, state IDLE. Reset mid-packet aborts immediately to these values; buffered data is discarded.
- Storage: shift register plus one holding buffer. in_ready = buffer empty AND state in {IDLE, SHIFT} AND last word not yet accepted. Acceptance is independent of bit_en.
- States: IDLE, SHIFT, STUFF, EOP_SE0, EOP_J.
- IDLE: line J, oe=0. Acceptance loads the word directly to the shifter and enters SHIFT; busy=1 from that edge.
- SHIFT, on bit_en: drive current bit. Data 0 toggles tx_nrzi; data 1 holds it. oe=1 from the first such edge. A 0 clears the ones counter; a 1 increments it. If the counter reaches STUFF_LEN, next state is STUFF and the shifter does not advance further. On the final bit of a word, reload from the buffer once any pending stuff is done.
- STUFF, on bit_en: toggle tx_nrzi, clear the counter, return to SHIFT (next data bit) or to end-of-word handling.
- End of word with no buffered word: if the last word was sent, go to EOP_SE0. Otherwise pulse underrun and go to EOP_SE0, truncating the packet.
- The ones counter carries across word boundaries within a packet and is cleared at packet start.
- Stuff due after the final data bit is emitted before the EOP.
- EOP_SE0: tx_dp=tx_dm=0 for EOP_SE0_BITS bit_en edges. EOP_J: one bit_en edge of J (dp=1, dm=0, tx_nrzi=1, oe=1). Next bit_en edge: oe=0, IDLE, busy=0.
- Line mapping outside SE0: tx_dp=tx_nrzi, tx_dm=~tx_nrzi.
- bit_en=0: all line outputs and the counter hold. Handshake still operates.
- Latency: first line bit appears on the first bit_en edge strictly after the acceptance edge.
- Counter width: $clog2(STUFF_LEN+1).

Test Plan:
- Single word 0x80, last=1, bit_en constant 1 -> tx_nrzi sequence 0,1,0,1,0,1,0,0. Then dp=dm=0 for 2 bits, then J with oe=1, then oe=0; busy falls the same edge; underrun never pulses.
- Words 0xFF then 0xFF(last) -> 18 line bits: tx_nrzi 1x6, 0 (stuff), 0x6, 1 (stuff), 1x4, then EOP.
- Word 0xFC last -> bits 0,0,1x6 give tx_nrzi 0,1,1,1,1,1,1,1. Stuff toggles to 0 before SE0, so 9 bit times precede EOP.
- Send 0x55 with last=0 and hold in_valid low -> underrun pulses once at word end, EOP follows, in_ready=0 until IDLE.
- bit_en every 4th clk with in_valid toggling randomly -> line bits change only on strobe edges. Word order and content are preserved, and in_ready drops while the buffer is full.
- Assert rst during bit 3 of the second word -> the same clk: oe=0, dp=1, dm=0, busy=0, in_ready=1. The next packet starts with the ones counter at 0.
